// File: rtl/seq_mag_comparator_pkg.sv
// cmp_pkg: shared types and constants for seq_mag_comparator.
//   cmp_state_t  : FSM states IDLE / RUN / DONE
//   CMP_LT/GT/EQ : one-hot {lt,gt,eq} result encodings
//   cycles_width : width of the cycles output, clog2(WIDTH/DIGIT)+1
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  // +1 so the count can hold N itself (all slices equal)
  function automatic int cycles_width(input int width, input int digit);
    return $clog2(width / digit) + 1;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_slice_cmp.sv
// slice_cmp: combinational unsigned compare of one DIGIT-bit slice.
//   i_a, i_b : slice operands
//   o_lt/o_gt/o_eq : i_a < / > / == i_b
module slice_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_lt,
  output logic             o_gt,
  output logic             o_eq
);

  assign o_lt = (i_a <  i_b);
  assign o_gt = (i_a >  i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle magnitude comparator, DIGIT bits per cycle,
// MSB slice first, early exit on the first differing slice.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (in_ready high only in IDLE)
//   a, b, signed_mode    : operands, two's complement when signed_mode=1
//   out_valid/out_ready  : result handshake
//   lt, gt, eq           : registered one-hot result
//   cycles               : RUN cycles the compare took
// Build option: define CMP_SIGNED_EN to honour signed_mode; otherwise all
// compares are unsigned and signed_mode is left unconnected internally.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  localparam int CW   = cycles_width(WIDTH, DIGIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [CW-1:0]    cycles
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  cmp_state_t       r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_lt, r_gt, r_eq, r_out_valid;

  logic                      w_accept;
  logic [WIDTH-1:0]          w_a, w_b;
  logic [N-1:0][DIGIT-1:0]   w_a_sl, w_b_sl;
  logic                      w_lt, w_gt, w_eq;
  logic [2:0]                w_res;

  assign w_accept = in_valid && (r_state == IDLE);

`ifdef CMP_SIGNED_EN
  logic r_sgn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_sgn <= 1'b0;
    else if (w_accept) r_sgn <= signed_mode;
  end

  // Offset-binary: flipping the sign bit turns two's complement order into
  // unsigned order, so the slice comparator stays unsigned.
  assign w_a = {r_a[WIDTH-1] ^ r_sgn, r_a[WIDTH-2:0]};
  assign w_b = {r_b[WIDTH-1] ^ r_sgn, r_b[WIDTH-2:0]};
`else
  logic w_unused_sgn;
  assign w_unused_sgn = signed_mode;
  assign w_a = r_a;
  assign w_b = r_b;
`endif

  assign w_a_sl = w_a;
  assign w_b_sl = w_b;

  slice_cmp #(.DIGIT(DIGIT)) u_slice (
    .i_a (w_a_sl[r_idx]),
    .i_b (w_b_sl[r_idx]),
    .o_lt(w_lt),
    .o_gt(w_gt),
    .o_eq(w_eq)
  );

  assign w_res = w_lt ? CMP_LT : (w_gt ? CMP_GT : CMP_EQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_lt        <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_idx   <= LAST_IDX;
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (!w_eq) begin
            {r_lt, r_gt, r_eq} <= w_res;
            r_out_valid        <= 1'b1;
            r_state            <= DONE;
          end else if (r_idx == '0) begin
            {r_lt, r_gt, r_eq} <= CMP_EQ;
            r_out_valid        <= 1'b1;
            r_state            <= DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign lt        = r_lt;
  assign gt        = r_gt;
  assign eq        = r_eq;
  assign cycles    = r_cnt;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: three instances (8/2, 6/3, 8/1), directed
// steps plus random sweeps, expected results queued at accept and popped at
// out_valid. Expectations follow CMP_SIGNED_EN as the RTL is built.
module tb_seq_mag_comparator;

  typedef struct {
    int         dut;
    logic [2:0] flags;
    logic [3:0] cyc;
  } exp_t;

  logic clk, rst_n;
  logic [2:0]      iv, sg, ordy;
  logic [2:0][7:0] a_v, b_v;
  logic [2:0]      ir, ov, lt_w, gt_w, eq_w;
  logic [2:0]      c0;
  logic [1:0]      c1;
  logic [3:0]      c2;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_mag_comparator #(.WIDTH(8), .DIGIT(2)) u_d82 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_v[0]), .b(b_v[0]), .signed_mode(sg[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .lt(lt_w[0]), .gt(gt_w[0]), .eq(eq_w[0]), .cycles(c0));

  seq_mag_comparator #(.WIDTH(6), .DIGIT(3)) u_d63 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_v[1][5:0]), .b(b_v[1][5:0]), .signed_mode(sg[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .lt(lt_w[1]), .gt(gt_w[1]), .eq(eq_w[1]), .cycles(c1));

  seq_mag_comparator #(.WIDTH(8), .DIGIT(1)) u_d81 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_v[2]), .b(b_v[2]), .signed_mode(sg[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .lt(lt_w[2]), .gt(gt_w[2]), .eq(eq_w[2]), .cycles(c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wd(input int d);  return (d == 1) ? 6 : 8; endfunction
  function automatic int dg(input int d);  return (d == 0) ? 2 : (d == 1) ? 3 : 1; endfunction
  function automatic int nsl(input int d); return wd(d) / dg(d); endfunction

  function automatic logic [2:0] flg(input int d);
    return {lt_w[d], gt_w[d], eq_w[d]};
  endfunction

  function automatic logic [3:0] cycv(input int d);
    case (d)
      0:       return {1'b0, c0};
      1:       return {2'b0, c1};
      default: return c2;
    endcase
  endfunction

  // Reference: full-width integer compare for the flags; the cycle count is
  // the 1-based slice (from the top) holding the highest differing bit.
  function automatic exp_t model(input int d, input logic [7:0] x, input logic [7:0] y,
                                 input bit s);
    exp_t e;
    int w, sx, sy;
    bit use_sgn;
    logic [7:0] msk, diff;
    w    = wd(d);
    msk  = 8'((1 << w) - 1);
    diff = (x ^ y) & msk;
    sx   = int'(x & msk);
    sy   = int'(y & msk);
`ifdef CMP_SIGNED_EN
    use_sgn = s;
`else
    use_sgn = s & 1'b0;
`endif
    if (use_sgn) begin
      if (sx >= (1 << (w - 1))) sx = sx - (1 << w);
      if (sy >= (1 << (w - 1))) sy = sy - (1 << w);
    end
    e.dut   = d;
    e.flags = (sx < sy) ? 3'b100 : (sx > sy) ? 3'b010 : 3'b001;
    e.cyc   = 4'(nsl(d));
    for (int h = 0; h < w; h++)
      if (diff[h]) e.cyc = 4'((w - 1 - h) / dg(d) + 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance d. hold = cycles of out_ready=0 in DONE;
  // intrude drives a conflicting in_valid/operand pair while busy.
  task automatic run(input int d, input logic [7:0] x, input logic [7:0] y,
                     input bit s, input int hold, input bit intrude);
    exp_t e, g;
    int k;
    e = model(d, x, y, s);
    sb.push_back(e);
    chk("in_ready_idle", ir[d], 1);
    a_v[d] = x; b_v[d] = y; sg[d] = s; iv[d] = 1'b1;
    tick;
    if (intrude) begin
      a_v[d] = ~x; b_v[d] = ~y; sg[d] = ~s;
    end else begin
      iv[d] = 1'b0;
    end
    k = 0;
    do begin
      tick;
      k++;
    end while (!ov[d] && k < 20);
    g = sb.pop_front();
    chk("out_valid_seen", ov[d], 1);
    chk("latency", k, g.cyc);
    chk("flags", flg(d), g.flags);
    chk("cycles", cycv(d), g.cyc);
    chk("cycles_le_n", (int'(cycv(d)) <= nsl(d)), 1);
    chk("in_ready_busy", ir[d], 0);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", ov[d], 1);
      chk("hold_flags", flg(d), g.flags);
      chk("hold_cycles", cycv(d), g.cyc);
      chk("hold_in_ready", ir[d], 0);
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    tick;
    ordy[d] = 1'b0;
    chk("release_in_ready", ir[d], 1);
    chk("release_valid", ov[d], 0);
  endtask

  task automatic chk_reset(input string tag, input int d);
    chk({tag, "_in_ready"}, ir[d], 1);
    chk({tag, "_valid"},    ov[d], 0);
    chk({tag, "_flags"},    flg(d), 0);
    chk({tag, "_cycles"},   cycv(d), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0; sg = '0; ordy = '0; a_v = '0; b_v = '0;
    #3;
    for (int d = 0; d < 3; d++) chk_reset("reset", d);
    tick;
    rst_n = 1'b1;
    tick;
    chk_reset("post_reset", 0);

    // top slice differs: 1-cycle latency; signed flips the answer
    run(0, 8'h80, 8'h7F, 1'b0, 0, 1'b0);
    run(0, 8'h80, 8'h7F, 1'b1, 0, 1'b0);
    run(0, 8'h5A, 8'h5A, 1'b0, 0, 1'b0);
    run(0, 8'h12, 8'h13, 1'b0, 0, 1'b0);
    run(0, 8'hFF, 8'h01, 1'b1, 0, 1'b0);

    // backpressure with ignored operands arriving during RUN and DONE
    run(0, 8'h34, 8'h31, 1'b0, 3, 1'b1);
    tick;
    chk("no_spurious_accept", ir[0], 1);

    // asynchronous reset two cycles into RUN
    a_v[0] = 8'h01; b_v[0] = 8'h02; sg[0] = 1'b0; iv[0] = 1'b1;
    tick;
    iv[0] = 1'b0;
    tick;
    tick;
    chk("pre_reset_busy", ir[0], 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_run_reset", 0);
    #1;
    rst_n = 1'b1;
    tick;
    chk_reset("after_mid_reset", 0);
    run(0, 8'h01, 8'h02, 1'b0, 0, 1'b0);

    // random sweeps on all three geometries
    for (int d = 0; d < 3; d++) begin
      run(d, 8'h00, 8'h00, 1'b1, 0, 1'b0);
      for (int i = 0; i < 15; i++)
        run(d, 8'($urandom), 8'($urandom), 1'($urandom), i % 2, 1'b0);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Multi-cycle, parametrised magnitude comparator. It compares two WIDTH-bit operands DIGIT bits per cycle, starting at the most-significant slice, and stops at the first slice that differs. Results are registered LT/GT/EQ flags. It sits behind a valid/ready operand interface and feeds downstream sort and limit-check logic. It generalises the team's combinational 3-bit comparator in width, adds optional signed mode, and adds flow control.

## Interface
Parameters:
- WIDTH, default 8: operand width. Must be ≥ 2 and an exact multiple of DIGIT.
- DIGIT, default 2: bits compared per cycle. Range 1..WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands. High only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  when high, operands are two's complement. Sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- lt  out  1  A < B.
- gt  out  1  A > B.
- eq  out  1  A == B.
- cycles  out  clog2(WIDTH/DIGIT)+1  number of RUN cycles the comparison took.

## Operation
- N = WIDTH/DIGIT slices. Slice N-1 holds the most-significant bits.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and signed_mode; set slice index to N-1 and cycle count to 0; go to RUN.
  - RUN: each cycle, compare the current slice and increment the cycle count.
    - Slice differs: register lt/gt for that slice (eq=0) and go to DONE.
    - Slice equal and index = 0: register eq=1, lt=gt=0 and go to DONE.
    - Otherwise: decrement the index and stay in RUN.
  - DONE: out_valid=1. Outputs stay stable until out_valid&&out_ready, then go to IDLE.
- Signed compare: the MSB of each operand is inverted before the top slice is compared. This offset-binary mapping makes the unsigned compare give the signed result.
- Exactly one of lt/gt/eq is 1 whenever out_valid=1.
- in_valid while not in IDLE is ignored; the operands are not captured.
- out_ready while out_valid=0 has no effect.
- Reset (asynchronous, any state, including mid-RUN): state=IDLE; out_valid=0, lt=0, gt=0, eq=0, cycles=0; in_ready=1 once rst_n is released. Any operation in progress is discarded.

## Timing
- Accept occurs at edge E0.
- The first differing slice, counted from the top as 1-based j, is resolved at edge E0+j. out_valid is high from that edge on, and cycles=j.
- Equal operands resolve at E0+N with cycles=N.
- Minimum latency is 1 cycle; maximum is N cycles.
- The DONE→IDLE transition happens at the edge where out_valid&&out_ready. in_ready rises in the same edge.
- The next accept is possible one cycle later, so throughput is at most one comparison per (j+2) cycles.
- All outputs are registered. There is no combinational path from any input to any output, except that in_ready depends only on state.

## Configuration
- Macro CMP_SIGNED_EN.
- Defined: signed_mode is honoured as described above.
- Undefined:
  - signed_mode is ignored and all compares are unsigned.
  - The MSB-inversion logic and the signed_mode capture register are not synthesised.
  - The port remains present so the interface is unchanged.

## Structure
- Package cmp_pkg holds:
  - the state enum cmp_state_t (IDLE, RUN, DONE);
  - the 3-bit result encoding constants CMP_LT=3'b100, CMP_GT=3'b010, CMP_EQ=3'b001;
  - a function computing the cycles width from WIDTH and DIGIT.
- Sub-module slice_cmp (parameter DIGIT): purely combinational DIGIT-bit compare producing lt/gt/eq. It is instanced once, fed by a mux on the slice index.
- The top level holds the FSM, operand registers, index counter, cycle counter and result registers.

## Test plan
- WIDTH=8, DIGIT=2, CMP_SIGNED_EN defined, signed_mode=0, a=0x80, b=0x7F → gt=1, cycles=1, out_valid 1 cycle after accept.
- Same operands with signed_mode=1 → lt=1, cycles=1.
- a=b=0x5A → eq=1, cycles=4. a=0x12, b=0x13 → lt=1, cycles=4.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → lt/gt/eq/cycles stable and in_ready=0 throughout. in_valid pulsed during RUN/DONE with new operands → ignored. Release out_ready → in_ready=1 the next cycle.
- Assert rst_n=0 mid-RUN (a=0x01, b=0x02, after 2 RUN cycles) → all outputs 0 immediately and state IDLE. A fresh compare after reset completes correctly.
- Build without CMP_SIGNED_EN: a=0x80, b=0x7F, signed_mode=1 → gt=1.
- Sweep WIDTH=6, DIGIT=3 and WIDTH=8, DIGIT=1 with random operands against a reference model → results match and cycles ≤ N.
